serial_link: RTL and testbench
==============================

SERIAL_LINK -- requirements
Module: serial_link

Interface
REQ-001 Parameter CLK_DIV, default 512, cpu clk cycles per serial bit (8192 Hz at 4.194304 MHz); even, >=4.
REQ-002 clk  input  1  CPU clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 wdata  input  8  CPU write data.
REQ-005 sb_wr  input  1  single-cycle write strobe for SB (FF01).
REQ-006 sc_wr  input  1  single-cycle write strobe for SC (FF02).
REQ-007 sb  output  8  current SB shift register value.
REQ-008 sc  output  8  SC readback: {busy, 6'b111111, clk_sel}.
REQ-009 serial_int  output  1  one-cycle pulse on transfer completion, feeds interrupt_st[3].
REQ-010 sclk_out  output  1  link clock driven when clk_sel=1; idles high.
REQ-011 sclk_oe  output  1  high while clk_sel=1.
REQ-012 sclk_in  input  1  asynchronous link clock from peer.
REQ-013 sout  output  1  serial data out, MSB first; idles high.
REQ-014 sin  input  1  serial data in.

Function
REQ-015 FSM states: IDLE, LOW (sclk low phase), HIGH (sclk high phase), DONE.
REQ-016 sc_wr with wdata[7]=1 in IDLE: load clk_sel=wdata[0], busy=1, bit count=0, go to LOW.
REQ-017 On LOW entry, sout=sb[7] and sclk_out=0 (internal mode).
REQ-018 Internal mode: each phase lasts CLK_DIV/2 cycles, counted by a phase counter reset on every phase entry.
REQ-019 LOW->HIGH: sclk_out=1; sb <= {sb[6:0], sin_sampled}; bit count increments.
REQ-020 HIGH->LOW when bit count<8; HIGH->DONE when bit count=8.
REQ-021 External mode: sclk_in passes a 2-flop synchronizer; synchronized falling edge drives LOW entry, rising edge drives the shift; no phase counter.
REQ-022 sin is sampled through a 2-flop synchronizer in both modes.
REQ-023 DONE lasts one cycle: busy=0, serial_int=1, sout=1, then IDLE.
REQ-024 Total internal-mode transfer latency from sc_wr to serial_int: 8*CLK_DIV+1 cycles.
REQ-025 sb_wr in IDLE loads sb=wdata; sb_wr while busy is ignored.
REQ-026 sc_wr with wdata[7]=0 while busy aborts: IDLE, busy=0, sout=1, sclk_out=1, no serial_int, sb keeps its partial value.
REQ-027 sc_wr with wdata[7]=1 while busy is ignored except clk_sel, which is latched only in IDLE.
REQ-028 sc_wr in the same cycle as DONE: write takes effect, serial_int still pulses.
REQ-029 sb_wr and sc_wr in the same IDLE cycle: sb loads first; the transfer shifts the new value.

Reset
REQ-030 On rst: state=IDLE, sb=8'h00, busy=0, clk_sel=0, serial_int=0, sout=1, sclk_out=1, counters and synchronizers at 0/idle-high.
REQ-031 rst mid-transfer abandons it with no serial_int.

Configuration
REQ-032 SERIAL_EXT_CLK_EN defined: external-clock mode per REQ-021.
REQ-033 SERIAL_EXT_CLK_EN undefined: clk_sel forced 1, sclk_in ignored, sc[0] always reads 1, sclk_in synchronizer not built.

Structure
REQ-034 Shared constants package holds SERIAL_CLK_DIV default, SB/SC addresses (16'hFF01/16'hFF02), and the FSM state enum serial_state_t.
REQ-035 One sub-module, link_sync (2-flop synchronizer with edge detect), instantiated for sin and sclk_in.

Verification
REQ-036 Internal mode, sb=8'hA5, sin tied to a loopback of sout -> after 8*CLK_DIV+1 cycles, sb=8'hA5, serial_int pulses once, sc[7]=0.
REQ-037 Internal mode, sb=8'h3C, sin held 1 -> sout shows 0,0,1,1,1,1,0,0 at LOW entries; final sb=8'hFF.
REQ-038 External mode, peer drives 8 sclk_in cycles at 1/64 clk with sin pattern 8'h5A -> sb=8'h5A, serial_int pulses.
REQ-039 Start, then sc_wr 8'h01 after 3 bits -> busy=0, no serial_int, sout=1, sb holds 3 shifted bits.
REQ-040 sb_wr 8'hFF mid-transfer -> ignored; rst asserted after 4 bits -> sb=8'h00, busy=0, no serial_int.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Shared constants and types for the serial link port (SB/SC registers).
package serial_link_pkg;

  localparam int          SERIAL_CLK_DIV = 512;
  localparam logic [15:0] SB_ADDR        = 16'hFF01;
  localparam logic [15:0] SC_ADDR        = 16'hFF02;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } serial_state_t;

  // SC readback: unused bits read as ones.
  function automatic logic [7:0] sc_value(input logic busy, input logic clk_sel);
    return {busy, 6'b111111, clk_sel};
  endfunction

endpackage

// File: rtl/link_sync.sv
// Two-flop synchronizer with rising/falling edge detect on the synchronized value.
module link_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // NOTE: non-blocking assignments make all three flops sample the pre-edge
  // values, so the chain really is three stages deep rather than collapsing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/serial_link.sv
// Serial link port: SB shift register, SC control, internal/external bit clock.
// Define SERIAL_EXT_CLK_EN to build the external (peer-clocked) mode.
module serial_link
  import serial_link_pkg::*;
#(
  parameter int CLK_DIV = SERIAL_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wdata,
  input  logic       sb_wr,
  input  logic       sc_wr,
  output logic [7:0] sb,
  output logic [7:0] sc,
  output logic       serial_int,
  output logic       sclk_out,
  output logic       sclk_oe,
  input  logic       sclk_in,
  output logic       sout,
  input  logic       sin
);

  localparam int               HALF       = CLK_DIV / 2;
  localparam int               CNT_W      = $clog2(HALF);
  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(HALF - 1);

`ifdef SERIAL_EXT_CLK_EN
  localparam logic CLK_SEL_RST = 1'b0;
`else
  localparam logic CLK_SEL_RST = 1'b1;
`endif

  serial_state_t    state_q, state_d;
  logic [7:0]       sb_q, sb_d;
  logic             clk_sel_q, clk_sel_d;
  logic             sout_q, sout_d;
  logic             sclk_q, sclk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;

  logic sin_s;
  logic ext_mode;
  logic ext_rise;
  logic ext_fall;
  logic phase_end;
  logic abort;
  logic unused_sin_rise;
  logic unused_sin_fall;

  link_sync #(.RESET_VAL(1'b1)) u_sin_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sin),
    .q_o    (sin_s),
    .rise_o (unused_sin_rise),
    .fall_o (unused_sin_fall)
  );

`ifdef SERIAL_EXT_CLK_EN
  logic unused_sclk_s;

  link_sync #(.RESET_VAL(1'b1)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sclk_in),
    .q_o    (unused_sclk_s),
    .rise_o (ext_rise),
    .fall_o (ext_fall)
  );

  assign ext_mode = ~clk_sel_q;
`else
  logic unused_sclk_in;

  assign unused_sclk_in = sclk_in;
  assign ext_rise       = 1'b0;
  assign ext_fall       = 1'b0;
  assign ext_mode       = 1'b0;
`endif

  assign abort = sc_wr & ~wdata[7];

  // NOTE: every always_comb output gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    sb_d      = sb_q;
    clk_sel_d = clk_sel_q;
    sout_d    = sout_q;
    sclk_d    = sclk_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    phase_end = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (sb_wr) sb_d = wdata;
        if (sc_wr) begin
`ifdef SERIAL_EXT_CLK_EN
          clk_sel_d = wdata[0];
`else
          clk_sel_d = 1'b1;
`endif
          if (wdata[7]) begin
            // sb_d already carries a same-cycle SB write.
            state_d = ST_LOW;
            bit_d   = 4'd0;
            cnt_d   = '0;
            sout_d  = sb_d[7];
            sclk_d  = ~clk_sel_d;
          end
        end
      end

      ST_LOW: begin
        cnt_d     = cnt_q + 1'b1;
        phase_end = ext_mode ? ext_rise : (cnt_q == PHASE_LAST);
        if (abort) begin
          state_d = ST_IDLE;
          sout_d  = 1'b1;
          sclk_d  = 1'b1;
          cnt_d   = '0;
        end else if (phase_end) begin
          state_d = ST_HIGH;
          sclk_d  = 1'b1;
          sb_d    = {sb_q[6:0], sin_s};
          bit_d   = bit_q + 4'd1;
          cnt_d   = '0;
        end
      end

      ST_HIGH: begin
        cnt_d = cnt_q + 1'b1;
        // A peer clock need not fall again after the eighth bit.
        phase_end = ext_mode ? (ext_fall || bit_q == 4'd8) : (cnt_q == PHASE_LAST);
        if (abort) begin
          state_d = ST_IDLE;
          sout_d  = 1'b1;
          sclk_d  = 1'b1;
          cnt_d   = '0;
        end else if (phase_end) begin
          cnt_d = '0;
          if (bit_q == 4'd8) begin
            state_d = ST_DONE;
            sout_d  = 1'b1;
            sclk_d  = 1'b1;
          end else begin
            state_d = ST_LOW;
            sout_d  = sb_q[7];
            sclk_d  = ext_mode;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sb_q      <= 8'h00;
      clk_sel_q <= CLK_SEL_RST;
      sout_q    <= 1'b1;
      sclk_q    <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      sb_q      <= sb_d;
      clk_sel_q <= clk_sel_d;
      sout_q    <= sout_d;
      sclk_q    <= sclk_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
    end
  end

  assign sb         = sb_q;
  assign sc         = sc_value((state_q == ST_LOW) || (state_q == ST_HIGH), clk_sel_q);
  assign serial_int = (state_q == ST_DONE);
  assign sclk_out   = sclk_q;
  assign sclk_oe    = clk_sel_q;
  assign sout       = sout_q;

endmodule

// File: tb/tb_serial_link.sv
// Directed self-checking bench for serial_link (internal mode always,
// external mode when SERIAL_EXT_CLK_EN is defined).
module tb_serial_link;

  localparam int D = 32;
  localparam int H = D / 2;

`ifdef SERIAL_EXT_CLK_EN
  localparam logic [7:0] SC_RST = 8'h7E;
  localparam logic       OE_RST = 1'b0;
`else
  localparam logic [7:0] SC_RST = 8'h7F;
  localparam logic       OE_RST = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wdata = 8'h00;
  logic       sb_wr = 1'b0;
  logic       sc_wr = 1'b0;
  logic [7:0] sb;
  logic [7:0] sc;
  logic       serial_int;
  logic       sclk_out;
  logic       sclk_oe;
  logic       sclk_in = 1'b1;
  logic       sout;
  logic       sin;
  logic       loop_en = 1'b0;
  logic       sin_drv = 1'b1;

  int errors = 0;
  int checks = 0;
  int cyc;
  int pulses;
  int pulse_at;
  logic [7:0] sout_bits;

  assign sin = loop_en ? sout : sin_drv;

  always #5 clk = ~clk;

  serial_link #(.CLK_DIV(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .wdata      (wdata),
    .sb_wr      (sb_wr),
    .sc_wr      (sc_wr),
    .sb         (sb),
    .sc         (sc),
    .serial_int (serial_int),
    .sclk_out   (sclk_out),
    .sclk_oe    (sclk_oe),
    .sclk_in    (sclk_in),
    .sout       (sout),
    .sin        (sin)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_sb(input logic [7:0] v);
    wdata = v;
    sb_wr = 1'b1;
    tick();
    sb_wr = 1'b0;
  endtask

  // Start a transfer; cyc counts edges with the start edge as cycle 0.
  task automatic do_start(input logic [7:0] scv, input logic also_sb);
    wdata = scv;
    sc_wr = 1'b1;
    sb_wr = also_sb;
    tick();
    sc_wr = 1'b0;
    sb_wr = 1'b0;
    cyc       = 0;
    pulses    = 0;
    pulse_at  = -1;
    sout_bits = {7'd0, sout};
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      cyc++;
      if (cyc % D == 0 && cyc < 8 * D) sout_bits = {sout_bits[6:0], sout};
      if (serial_int) begin
        pulses++;
        if (pulse_at < 0) pulse_at = cyc;
      end
    end
  endtask

  initial begin
    // Reset state
    #23;
    check("rst_sb", sb, 8'h00);
    check("rst_sc", sc, SC_RST);
    check("rst_int", serial_int, 1'b0);
    check("rst_sout", sout, 1'b1);
    check("rst_sclk", sclk_out, 1'b1);
    check("rst_oe", sclk_oe, OE_RST);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Loopback rotation of A5, latency 8*D+1
    loop_en = 1'b1;
    write_sb(8'hA5);
    check("a_sb_load", sb, 8'hA5);
    do_start(8'h81, 1'b0);
    check("a_busy", sc, 8'hFF);
    check("a_sout0", sout, 1'b1);
    check("a_sclk_low", sclk_out, 1'b0);
    run_ticks(H);
    check("a_sclk_high", sclk_out, 1'b1);
    check("a_sb_shift1", sb, 8'h4B);
    run_ticks(8 * D - H);
    check("a_latency", pulse_at, 8 * D);
    check("a_sb_final", sb, 8'hA5);
    check("a_sc_done", sc, 8'h7F);
    check("a_sout_done", sout, 1'b1);
    run_ticks(1);
    check("a_int_once", pulses, 1);
    check("a_int_low", serial_int, 1'b0);
    check("a_sout_bits", sout_bits, 8'hA5);

    // 3C with sin held high
    loop_en = 1'b0;
    sin_drv = 1'b1;
    write_sb(8'h3C);
    do_start(8'h81, 1'b0);
    run_ticks(8 * D + 1);
    check("b_sout_bits", sout_bits, 8'h3C);
    check("b_sb_final", sb, 8'hFF);
    check("b_pulses", pulses, 1);

    // SB and SC written together: new SB value is shifted
    loop_en = 1'b1;
    write_sb(8'h00);
    do_start(8'h81, 1'b1);
    check("c_sb_load", sb, 8'h81);
    check("c_sout0", sout, 1'b1);
    run_ticks(8 * D + 1);
    check("c_sb_final", sb, 8'h81);
    check("c_sout_bits", sout_bits, 8'h81);
    check("c_pulses", pulses, 1);

    // SC write during DONE restarts while serial_int still pulses
    loop_en = 1'b0;
    sin_drv = 1'b0;
    write_sb(8'hF0);
    do_start(8'h81, 1'b0);
    run_ticks(8 * D - 1);
    check("d_no_early_int", pulses, 0);
    run_ticks(1);
    check("d_int_done", serial_int, 1'b1);
    check("d_sb_zero", sb, 8'h00);
    wdata = 8'h81;
    sc_wr = 1'b1;
    tick();
    sc_wr = 1'b0;
    check("d_restart_busy", sc, 8'hFF);
    check("d_int_cleared", serial_int, 1'b0);
    check("d_restart_sout", sout, 1'b0);
    wdata = 8'h01;
    sc_wr = 1'b1;
    tick();
    sc_wr = 1'b0;
    check("d_abort_sc", sc, 8'h7F);

    // Abort after 3 bits
    sin_drv = 1'b0;
    write_sb(8'hA5);
    do_start(8'h81, 1'b0);
    run_ticks(2 * D + H + 4);
    check("e_sb_3bits", sb, 8'h28);
    check("e_busy", sc, 8'hFF);
    wdata = 8'h01;
    sc_wr = 1'b1;
    tick();
    sc_wr = 1'b0;
    check("e_abort_sc", sc, 8'h7F);
    check("e_abort_sout", sout, 1'b1);
    check("e_abort_sclk", sclk_out, 1'b1);
    check("e_abort_sb", sb, 8'h28);
    run_ticks(8 * D);
    check("e_no_int", pulses, 0);

    // Writes while busy ignored, then reset after 4 bits
    sin_drv = 1'b1;
    write_sb(8'hC3);
    do_start(8'h81, 1'b0);
    run_ticks(D + 3);
    wdata = 8'hFF;
    sb_wr = 1'b1;
    run_ticks(1);
    sb_wr = 1'b0;
    check("f_sb_wr_ignored", sb, 8'h87);
    wdata = 8'h80;
    sc_wr = 1'b1;
    run_ticks(1);
    sc_wr = 1'b0;
    check("f_sc_wr_ignored", sc, 8'hFF);
    run_ticks(3 * D + H + 2 - cyc);
    check("f_sb_4bits", sb, 8'h3F);
    rst = 1'b1;
    #2;
    check("f_rst_sb", sb, 8'h00);
    check("f_rst_sc", sc, SC_RST);
    check("f_rst_int", serial_int, 1'b0);
    check("f_rst_sout", sout, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    run_ticks(8 * D);
    check("f_no_int", pulses, 0);

`ifdef SERIAL_EXT_CLK_EN
    // Peer-clocked transfer of 5A at 1/64 clk
    begin
      logic [7:0] pat;
      pat = 8'h5A;
      write_sb(8'h99);
      do_start(8'h80, 1'b0);
      check("g_sc_ext", sc, 8'hFE);
      check("g_oe_ext", sclk_oe, 1'b0);
      check("g_sout0", sout, 1'b1);
      for (int b = 7; b >= 0; b--) begin
        sclk_in = 1'b0;
        sin_drv = pat[b];
        run_ticks(32);
        sclk_in = 1'b1;
        run_ticks(32);
      end
      run_ticks(4);
      check("g_sb_final", sb, 8'h5A);
      check("g_pulses", pulses, 1);
      check("g_sc_idle", sc, 8'h7E);
      check("g_sclk_idle", sclk_out, 1'b1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
